// File: rtl/regfile_mp_if.sv
// Purpose : bundles register-file address, data and write-port signals between decode/writeback and the register file.
// Ports   : master drives read addresses and both write ports; slave returns A/B/TEST read data and init_busy.
// Widths  : DW data bits, AW address bits (DEPTH = 2**AW).
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] regA;
  logic [AW-1:0] regB;
  logic [AW-1:0] regTEST;
  logic [DW-1:0] Adat;
  logic [DW-1:0] Bdat;
  logic [DW-1:0] TESTdat;
  logic          we0;
  logic [AW-1:0] regW0;
  logic [DW-1:0] Wdat0;
  logic          we1;
  logic [AW-1:0] regW1;
  logic [DW-1:0] Wdat1;
  logic          init_busy;

  modport master (
    output regA, regB, regTEST,
    output we0, regW0, Wdat0,
    output we1, regW1, Wdat1,
    input  Adat, Bdat, TESTdat, init_busy
  );

  modport slave (
    input  regA, regB, regTEST,
    input  we0, regW0, Wdat0,
    input  we1, regW1, Wdat1,
    output Adat, Bdat, TESTdat, init_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Purpose : multi-port register file, 3 async reads (A, B, TEST) and 2 sync writes (port 1 wins on collision),
//           optional hardwired-zero entry 0 and optional same-cycle write-to-read bypass; self-clears after reset.
// Ports   : clk, rst_n (sync active-low); bus (regfile_mp_if.slave) carries read addresses/data, write ports, init_busy.
// Timing  : reads combinational; writes land on the clock edge; clear sequence takes DEPTH edges after reset release.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          w_busy;
  logic          w_wr0;
  logic          w_wr1;
  logic [DW-1:0] r_mem [DEPTH];

  // State register: reset parks the sequencer at entry 0 of the clear pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_busy      = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy    = 1'b1;
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == AW'(DEPTH - 1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_idx_nxt = '0;
      end
      default: begin
        w_state_nxt = CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Writes to entry 0 are dropped entirely when it is hardwired to zero.
  assign w_wr0 = bus.we0 && !((ZERO_REG != 0) && (bus.regW0 == '0));
  assign w_wr1 = bus.we1 && !((ZERO_REG != 0) && (bus.regW1 == '0));

  // Port 1 is written after port 0 so it wins when both target one entry.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == CLEAR) begin
        r_mem[r_idx] <= '0;
      end else begin
        if (w_wr0) r_mem[bus.regW0] <= bus.Wdat0;
        if (w_wr1) r_mem[bus.regW1] <= bus.Wdat1;
      end
    end
  end

  function automatic logic [DW-1:0] f_read(
    input logic          busy,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] stored,
    input logic          we0,
    input logic [AW-1:0] w0,
    input logic [DW-1:0] d0,
    input logic          we1,
    input logic [AW-1:0] w1,
    input logic [DW-1:0] d1
  );
    if (busy)                                 return '0;
    if ((ZERO_REG != 0) && (addr == '0))      return '0;
    if ((BYPASS != 0) && we1 && (w1 == addr)) return d1;
    if ((BYPASS != 0) && we0 && (w0 == addr)) return d0;
    return stored;
  endfunction

  assign bus.Adat    = f_read(w_busy, bus.regA, r_mem[bus.regA],
                              bus.we0, bus.regW0, bus.Wdat0, bus.we1, bus.regW1, bus.Wdat1);
  assign bus.Bdat    = f_read(w_busy, bus.regB, r_mem[bus.regB],
                              bus.we0, bus.regW0, bus.Wdat0, bus.we1, bus.regW1, bus.Wdat1);
  assign bus.TESTdat = f_read(w_busy, bus.regTEST, r_mem[bus.regTEST],
                              bus.we0, bus.regW0, bus.Wdat0, bus.we1, bus.regW1, bus.Wdat1);
  assign bus.init_busy = w_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Purpose : checks regfile_mp in two builds side by side (ZERO_REG=1/BYPASS=1 and ZERO_REG=0/BYPASS=0).
// Ports   : none; both DUTs share clk/rst_n and receive identical stimulus through their own interfaces.
// Flow    : expected read/busy values are queued when a cycle is driven and popped against the DUT mid-cycle.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DW(32), .AW(5)) if_a ();
  regfile_mp_if #(.DW(32), .AW(5)) if_b ();

  regfile_mp #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut_zb (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  regfile_mp #(.DW(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  logic [4:0]  t_regA = '0, t_regB = '0, t_regT = '0, t_w0 = '0, t_w1 = '0;
  logic        t_we0 = 1'b0, t_we1 = 1'b0;
  logic [31:0] t_d0 = '0, t_d1 = '0;

  assign if_a.regA = t_regA;  assign if_b.regA = t_regA;
  assign if_a.regB = t_regB;  assign if_b.regB = t_regB;
  assign if_a.regTEST = t_regT; assign if_b.regTEST = t_regT;
  assign if_a.we0 = t_we0;    assign if_b.we0 = t_we0;
  assign if_a.regW0 = t_w0;   assign if_b.regW0 = t_w0;
  assign if_a.Wdat0 = t_d0;   assign if_b.Wdat0 = t_d0;
  assign if_a.we1 = t_we1;    assign if_b.we1 = t_we1;
  assign if_a.regW1 = t_w1;   assign if_b.regW1 = t_w1;
  assign if_a.Wdat1 = t_d1;   assign if_b.Wdat1 = t_d1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: m_mem[0] for the zero/bypass build, m_mem[1] for the plain build.
  logic [31:0] m_mem [2][32];
  int          rel_cnt = 0;
  bit          m_valid = 1'b0;

  function automatic bit m_busy();
    return (rel_cnt < 32);
  endfunction

  function automatic logic [31:0] exp_rd(input int cfg, input logic [4:0] a);
    if (m_busy())                            return 32'h0;
    if (cfg == 0 && a == 5'd0)               return 32'h0;
    if (cfg == 0 && t_we1 && t_w1 == a)      return t_d1;
    if (cfg == 0 && t_we0 && t_w0 == a)      return t_d0;
    return m_mem[cfg][a];
  endfunction

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  function automatic logic [31:0] obs_of(input int k);
    case (k)
      0: return if_a.Adat;
      1: return if_a.Bdat;
      2: return if_a.TESTdat;
      3: return {31'b0, if_a.init_busy};
      4: return if_b.Adat;
      5: return if_b.Bdat;
      6: return if_b.TESTdat;
      default: return {31'b0, if_b.init_busy};
    endcase
  endfunction

  task automatic push_exp();
    string pfx;
    for (int c = 0; c < 2; c++) begin
      pfx = (c == 0) ? "zb" : "nz";
      sb_q.push_back('{{pfx, ".A"},    exp_rd(c, t_regA)});
      sb_q.push_back('{{pfx, ".B"},    exp_rd(c, t_regB)});
      sb_q.push_back('{{pfx, ".TEST"}, exp_rd(c, t_regT)});
      sb_q.push_back('{{pfx, ".busy"}, {31'b0, m_busy()}});
    end
  endtask

  task automatic model_edge();
    bit busy_before;
    busy_before = m_busy();
    if (!rst_n) begin
      m_valid = 1'b1;
      rel_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[0][i] = '0;
        m_mem[1][i] = '0;
      end
    end else if (m_valid) begin
      if (!busy_before) begin
        if (t_we0 && t_w0 != 5'd0) m_mem[0][t_w0] = t_d0;
        if (t_we1 && t_w1 != 5'd0) m_mem[0][t_w1] = t_d1;
        if (t_we0) m_mem[1][t_w0] = t_d0;
        if (t_we1) m_mem[1][t_w1] = t_d1;
      end
      if (rel_cnt < 32) rel_cnt++;
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rt,
                     input logic e0, input logic [4:0] w0, input logic [31:0] d0,
                     input logic e1, input logic [4:0] w1, input logic [31:0] d1);
    sb_t e;
    rst_n = r; t_regA = ra; t_regB = rb; t_regT = rt;
    t_we0 = e0; t_w0 = w0; t_d0 = d0; t_we1 = e1; t_w1 = w1; t_d1 = d1;
    if (m_valid) push_exp();
    @(negedge clk);
    if (m_valid) begin
      for (int k = 0; k < 8; k++) begin
        e = sb_q.pop_front();
        chk(e.tag, obs_of(k), e.exp);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rd(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rt);
    cyc(1'b1, ra, rb, rt, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic init_seq();
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 5'd1, 32'hBAD0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 34; i++) rd(5'(i), 5'(31 - i), 5'(i));
  endtask

  initial begin
    // Reset and full clear, then sweep every entry on all three read ports.
    init_seq();
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i), 5'(i));

    // Basic write on port 0, read back next cycle; neighbour stays clear.
    cyc(1'b1, 5'd5, 5'd6, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    rd(5'd5, 5'd6, 5'd5);

    // Zero register via port 1.
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    rd(5'd0, 5'd5, 5'd0);

    // Collision on 9, then distinct addresses 3/4 in one cycle.
    cyc(1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'h5555);
    rd(5'd9, 5'd3, 5'd4);
    cyc(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'h5555);
    rd(5'd3, 5'd4, 5'd9);

    // Bypass: seed 7 with 0x11, overwrite with 0x22 while reading 7.
    cyc(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0);
    cyc(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
    cyc(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 5'd7, 32'h33, 1'b1, 5'd7, 32'h44);
    rd(5'd7, 5'd3, 5'd4);

    // Reset mid-clear: write 0xFF to 2, reset, abort clear near idx 10, reset again.
    cyc(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 5'd2, 32'hFF, 1'b0, 5'd0, 32'h0);
    rd(5'd2, 5'd2, 5'd2);
    cyc(1'b0, 5'd2, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 5'd2, 32'hFF, 1'b1, 5'd8, 32'h77);
    cyc(1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 5'd2, 32'hFF, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 33; i++) cyc(1'b1, 5'd2, 5'd8, 5'(i), 1'b1, 5'd2, 32'hFF, 1'b0, 5'd0, 32'h0);
    rd(5'd2, 5'd8, 5'd9);

    // Reset during RUN after 2 was rewritten.
    cyc(1'b1, 5'd2, 5'd2, 5'd2, 1'b1, 5'd2, 32'hFF, 1'b0, 5'd0, 32'h0);
    rd(5'd2, 5'd2, 5'd2);
    cyc(1'b0, 5'd2, 5'd2, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 33; i++) cyc(1'b1, 5'd2, 5'd4, 5'(i), 1'b1, 5'd2, 32'hEE, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'd2, 5'(i));

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
